gate_array_pipe: RTL and testbench
==================================

GATE_ARRAY_PIPE -- requirements
Module: gate_array_pipe

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set operand and result width in bits (legal 1..64).
REQ-002 Parameter CNTW, default 16, SHALL set the transaction counter width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset, sampled on rising clk.
REQ-005 in_valid  input  1  SHALL indicate that a, b and op are valid.
REQ-006 in_ready  output  1  SHALL indicate the block can accept an operation this cycle.
REQ-007 a  input  WIDTH  SHALL be operand A.
REQ-008 b  input  WIDTH  SHALL be operand B.
REQ-009 op  input  3  SHALL select the operation: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 illegal.
REQ-010 out_valid  output  1  SHALL indicate that y, y_red and err are valid.
REQ-011 out_ready  input  1  SHALL indicate that the consumer accepts the result this cycle.
REQ-012 y  output  WIDTH  SHALL be the bitwise result.
REQ-013 y_red  output  1  SHALL be the XOR-reduction (parity) of y.
REQ-014 err  output  1  SHALL flag that the result came from op=7.
REQ-015 op_count  output  CNTW  SHALL count accepted operations.

Function
REQ-016 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; produce SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-017 The block SHALL compute each operation bitwise over all WIDTH bits per the op encoding in REQ-009; for op=6, b SHALL be ignored.
REQ-018 For op=7, the block SHALL enqueue y=0, y_red=0 and err=1; for all other ops, err SHALL be 0.
REQ-019 Results SHALL be registered into a 2-entry FIFO (entry = y, y_red, err); the head entry SHALL drive the outputs.
REQ-020 Latency: an operation accepted into an empty FIFO at edge N SHALL appear with out_valid=1 immediately after edge N (one-cycle latency); there SHALL be no combinational path from a/b/op to y.
REQ-021 in_ready SHALL equal (occupancy < 2), registered-state only, with no combinational dependence on out_ready.
REQ-022 out_valid SHALL equal (occupancy > 0).
REQ-023 Simultaneous accept and produce at occupancy 1 SHALL leave occupancy at 1, with the new entry behind the departing one.
REQ-024 At occupancy 2, in_ready SHALL be 0; an in_valid asserted then SHALL NOT be accepted or counted, and the FIFO contents SHALL be unchanged.
REQ-025 Produce at occupancy 0 SHALL be impossible; out_ready while out_valid=0 SHALL have no effect.
REQ-026 Results SHALL leave in acceptance order; no entry SHALL be dropped or duplicated.
REQ-027 Head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 op_count SHALL increment by 1 per accept, including op=7, and wrap from 2^CNTW-1 to 0.

Reset
REQ-029 While rst_n=0 at a rising edge: occupancy SHALL become 0, out_valid=0, in_ready=1, y=0, y_red=0, err=0 and op_count=0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries; no result SHALL appear after reset release until a new accept.
REQ-031 in_valid asserted during reset SHALL NOT be accepted.

Verification
REQ-032 WIDTH=8, out_ready=1: sweep op 0..5 with a=8'hF0, b=8'hCC -> y=C0, FC, 3F, 03, 3C, C3 respectively, y_red=0 for all, each one cycle after accept.
REQ-033 op=6, a=8'hA5, b=8'hFF -> y=8'h5A, y_red=0, err=0; op=7 -> y=0, err=1, op_count incremented.
REQ-034 out_ready=0, three back-to-back in_valid -> first two accepted, in_ready=0 from the cycle after the second accept, third held off; then out_ready=1 -> results emerge in order and the third is accepted.
REQ-035 Occupancy 1 with simultaneous accept and produce for 10 cycles -> out_valid stays 1, in_ready stays 1, results in order.
REQ-036 CNTW=4: 17 accepts -> op_count=1 (wrap).
REQ-037 Reset asserted with 2 entries buffered -> next cycle out_valid=0, in_ready=1, op_count=0.

Source files
------------

// File: rtl/gate_array_pipe.sv
// rtl/gate_array_pipe.sv - bitwise gate array with a 2-entry registered result FIFO
//
// Ports:
//   clk, rst_n            single clock, synchronous active-low reset
//   in_valid / in_ready   operation handshake (a, b, op)
//   a, b [WIDTH-1:0]      operands
//   op [2:0]              0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a, 7 illegal
//   out_valid / out_ready result handshake (y, y_red, err)
//   y [WIDTH-1:0]         bitwise result at the FIFO head
//   y_red                 parity of y
//   err                   head entry came from op=7
//   op_count [CNTW-1:0]   accepted-operation counter, wraps
module gate_array_pipe #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_red,
  output logic             err,
  output logic [CNTW-1:0]  op_count
);

  // Entry layout: {y, y_red, err}
  localparam int EW = WIDTH + 2;

  logic [EW-1:0]    head_q, head_d;
  logic [EW-1:0]    tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic [CNTW-1:0]  op_count_q, op_count_d;

  logic [WIDTH-1:0] res;
  logic             res_err;
  logic [EW-1:0]    new_entry;
  logic             accept;
  logic             produce;

  always_comb begin
    res     = '0;
    res_err = 1'b0;
    case (op)
      3'd0:    res = a & b;
      3'd1:    res = a | b;
      3'd2:    res = ~(a & b);
      3'd3:    res = ~(a | b);
      3'd4:    res = a ^ b;
      3'd5:    res = ~(a ^ b);
      3'd6:    res = ~a;
      default: begin
        res     = '0;
        res_err = 1'b1;
      end
    endcase
    new_entry = {res, ^res, res_err};
  end

  // Ready/valid come straight from the occupancy register, so neither
  // side of the handshake depends combinationally on the other.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign produce   = out_valid & out_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    op_count_d = op_count_q;

    if (accept) begin
      op_count_d = op_count_q + 1'b1;
    end

    case (count_q)
      2'd0: begin
        if (accept) begin
          head_d  = new_entry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (accept && produce) begin
          // Head departs; the new entry becomes the head directly.
          head_d = new_entry;
        end else if (accept) begin
          tail_d  = new_entry;
          count_d = 2'd2;
        end else if (produce) begin
          count_d = 2'd0;
        end
      end
      default: begin
        // Full: in_ready is low, so only a produce can happen.
        if (produce) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= 2'd0;
      op_count_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end

  assign y        = head_q[EW-1:2];
  assign y_red    = head_q[1];
  assign err      = head_q[0];
  assign op_count = op_count_q;

endmodule

// File: tb/tb_gate_array_pipe.sv
// tb/tb_gate_array_pipe.sv - self-checking bench for gate_array_pipe
module tb_gate_array_pipe;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [2:0]       op = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] y;
  logic             y_red;
  logic             err;
  logic [CNTW-1:0]  op_count;

  gate_array_pipe #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_red(y_red), .err(err),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             r;
    logic             e;
  } ent_t;

  ent_t mq[$];
  int   mcount = 0;

  function automatic ent_t model_op(logic [2:0] o, logic [WIDTH-1:0] x, logic [WIDTH-1:0] z);
    ent_t r;
    r.e = 1'b0;
    case (o)
      3'd0: r.y = x & z;
      3'd1: r.y = x | z;
      3'd2: r.y = ~(x & z);
      3'd3: r.y = ~(x | z);
      3'd4: r.y = x ^ z;
      3'd5: r.y = ~(x ^ z);
      3'd6: r.y = ~x;
      default: begin
        r.y = '0;
        r.e = 1'b1;
      end
    endcase
    r.r = ^r.y;
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of pending results and a modular counter.
  always @(posedge clk) begin
    bit acc, prd;
    if (!rst_n) begin
      mq.delete();
      mcount = 0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      prd = out_ready && (mq.size() > 0);
      if (prd) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(model_op(op, a, b));
        mcount = (mcount + 1) % (1 << CNTW);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, mq.size() < 2});
      chk("op_count", 64'(op_count), 64'(mcount));
      if (mq.size() > 0) begin
        chk("y", 64'(y), 64'(mq[0].y));
        chk("y_red", {63'd0, y_red}, {63'd0, mq[0].r});
        chk("err", {63'd0, err}, {63'd0, mq[0].e});
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] lit [6];

  initial begin
    lit[0] = 8'hC0; lit[1] = 8'hFC; lit[2] = 8'h3F;
    lit[3] = 8'h03; lit[4] = 8'h3C; lit[5] = 8'hC3;

    // Reset with in_valid high: must not be accepted.
    in_valid = 1'b1;
    op = 3'd1; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_y", 64'(y), 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("post_rst_idle", {63'd0, out_valid}, 64'd0);

    // Op sweep, one-cycle latency, continuous streaming.
    out_ready = 1'b1;
    a = 8'hF0; b = 8'hCC; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      op = 3'(i);
      @(negedge clk);
      chk("sweep_valid", {63'd0, out_valid}, 64'd1);
      chk("sweep_y", 64'(y), 64'(lit[i]));
      chk("sweep_red", {63'd0, y_red}, 64'd0);
      #1;
    end
    op = 3'd6; a = 8'hA5; b = 8'hFF;
    @(negedge clk);
    chk("not_y", 64'(y), 64'h5A);
    chk("not_red", {63'd0, y_red}, 64'd0);
    chk("not_err", {63'd0, err}, 64'd0);
    #1;
    op = 3'd7;
    @(negedge clk);
    chk("ill_y", 64'(y), 64'd0);
    chk("ill_err", {63'd0, err}, 64'd1);
    chk("ill_count", 64'(op_count), 64'd8);
    #1;
    in_valid = 1'b0;
    cyc();

    // Backpressure: two accepted, third held off.
    out_ready = 1'b0;
    in_valid = 1'b1; op = 3'd4; a = 8'h12; b = 8'h34;
    @(negedge clk);
    chk("bp_ready1", {63'd0, in_ready}, 64'd1);
    #1; a = 8'h56; b = 8'h0F;
    @(negedge clk);
    chk("bp_ready2", {63'd0, in_ready}, 64'd0);
    chk("bp_count2", 64'(op_count), 64'd10);
    #1; a = 8'h9A; b = 8'hFF;
    @(negedge clk);
    chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
    chk("bp_hold_count", 64'(op_count), 64'd10);
    chk("bp_hold_y", 64'(y), 64'h26);
    #1; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_y2", 64'(y), 64'h59);
    #1;
    @(negedge clk);
    chk("bp_y3", 64'(y), 64'h65);
    chk("bp_count3", 64'(op_count), 64'd11);
    #1; in_valid = 1'b0;
    cyc();

    // Occupancy 1 with simultaneous accept and produce.
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; a = 8'hFF; b = 8'h11;
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk("ovl_valid", {63'd0, out_valid}, 64'd1);
      chk("ovl_ready", {63'd0, in_ready}, 64'd1);
      #1;
    end
    in_valid = 1'b0;
    cyc();

    // Counter wrap: 17 accepts from reset.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_count", 64'(op_count), 64'd1);
    #1;

    // Reset with two entries buffered.
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd1; a = 8'h0F; b = 8'hF0;
    cyc();
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_valid", {63'd0, out_valid}, 64'd0);
    chk("rst2_ready", {63'd0, in_ready}, 64'd1);
    chk("rst2_count", 64'(op_count), 64'd0);
    chk("rst2_y", 64'(y), 64'd0);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    cyc();
    chk("rst2_no_ghost", {63'd0, out_valid}, 64'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      cyc();
    end
    rst_n = 1'b1; in_valid = 1'b0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
